// File: rtl/lake_harness_pkg.sv
// lake_harness_pkg
// Shared types and helpers for the lake stream harness.
//   state_e     : sequencer states (IDLE, LOAD, FLUSH, RUN, DONE)
//   clog2_min1  : address/select width helper, never returns less than 1
//   cap_aw      : capture address width, CAP_AW = clog2(CAP_DEPTH)
//   chan_w      : capture channel select width, CHAN_W = clog2(NUM_OUT), min 1
// CAP_AW and CHAN_W depend on the top's parameters, so the package supplies
// the derivation and the top instantiates the localparams from it.
package lake_harness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cap_aw(input int cap_depth);
        return clog2_min1(cap_depth);
    endfunction

    function automatic int chan_w(input int num_out);
        return clog2_min1(num_out);
    endfunction

endpackage

// File: rtl/lake_harness_capture_ram.sv
// lake_harness_capture_ram
// One capture buffer: DATA_WIDTH x DEPTH, one write port, one registered
// read port.
//   clk, rst : clock; rst clears only the read register, never the array
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, data one cycle after raddr
module lake_harness_capture_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int AW         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lake_stream_harness.sv
// lake_stream_harness
// Hardware stimulus/capture harness: on a start pulse it loads the DUT config,
// flushes for FLUSH_CYCLES, drives per-channel ramps for num_cycles and
// captures every DUT output channel into its own buffer for readback.
//   clk, rst                  : clock, synchronous active-high reset
//   start, num_cycles, stride, config_in : sequence request (sampled on start)
//   dut_config_memory, dut_flush, dut_port_in : DUT drive
//   dut_port_out              : DUT outputs to capture
//   rd_chan, rd_addr, rd_data : capture readback, 1-cycle latency
//   busy, done, overflow, cap_count, cycle_count : status
module lake_stream_harness
    import lake_harness_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int NUM_IN             = 1,
    parameter int NUM_OUT            = 1,
    parameter int CONFIG_MEMORY_SIZE = 512,
    parameter int FLUSH_CYCLES       = 2,
    parameter int CAP_DEPTH          = 1024,
    parameter int CYC_W              = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CYC_W-1:0]               num_cycles,
    input  logic [DATA_WIDTH-1:0]          stride,
    input  logic [CONFIG_MEMORY_SIZE-1:0]  config_in,
    output logic [CONFIG_MEMORY_SIZE-1:0]  dut_config_memory,
    output logic                           dut_flush,
    output logic [NUM_IN*DATA_WIDTH-1:0]   dut_port_in,
    input  logic [NUM_OUT*DATA_WIDTH-1:0]  dut_port_out,
    input  logic [chan_w(NUM_OUT)-1:0]     rd_chan,
    input  logic [cap_aw(CAP_DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [CYC_W-1:0]               cap_count,
    output logic [63:0]                    cycle_count
);

    localparam int CAP_AW = cap_aw(CAP_DEPTH);
    localparam int CHAN_W = chan_w(NUM_OUT);
    localparam int FC_W   = clog2_min1(FLUSH_CYCLES);

    localparam logic [FC_W-1:0]   FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CYC_W-1:0]  DEPTH_C    = CYC_W'(CAP_DEPTH);
    localparam logic [CHAN_W:0]   NUM_OUT_C  = (CHAN_W + 1)'(NUM_OUT);

    state_e                                state_q, state_d;
    logic [CYC_W-1:0]                      num_q, num_d;
    logic [DATA_WIDTH-1:0]                 stride_q, stride_d;
    logic [CONFIG_MEMORY_SIZE-1:0]         cfg_q, cfg_d;
    logic [FC_W-1:0]                       flush_cnt_q, flush_cnt_d;
    logic [CYC_W-1:0]                      run_idx_q, run_idx_d;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0]     acc_q, acc_d;
    logic                                  flush_q, flush_d;
    logic                                  busy_q, busy_d;
    logic                                  done_q, done_d;
    logic                                  ovf_q, ovf_d;
    logic [CYC_W-1:0]                      capc_q, capc_d;
    logic [63:0]                           cc_q;
    logic [CHAN_W-1:0]                     rd_chan_q;
    logic                                  rd_ok_q;

    // Status values loaded on every entry to DONE.
    logic                                  ovf_next;
    logic [CYC_W-1:0]                      capc_next;
    assign ovf_next  = (num_q > DEPTH_C);
    assign capc_next = ovf_next ? DEPTH_C : num_q;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        stride_d    = stride_q;
        cfg_d       = cfg_q;
        flush_cnt_d = flush_cnt_q;
        run_idx_d   = run_idx_q;
        acc_d       = acc_q;
        flush_d     = flush_q;
        busy_d      = busy_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        capc_d      = capc_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Config goes straight to the DUT register so it is
                    // already valid during the LOAD cycle.
                    num_d       = num_cycles;
                    stride_d    = stride;
                    cfg_d       = config_in;
                    ovf_d       = 1'b0;
                    capc_d      = '0;
                    flush_cnt_d = '0;
                    run_idx_d   = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                flush_d = 1'b1;
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_d = 1'b0;
                    if (num_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        ovf_d   = ovf_next;
                        capc_d  = capc_next;
                        state_d = ST_DONE;
                    end else begin
                        // Seed ramps with run index 0: channel c starts at c.
                        for (int c = 0; c < NUM_IN; c++) begin
                            acc_d[c] = DATA_WIDTH'(c);
                        end
                        state_d = ST_RUN;
                    end
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (run_idx_q == num_q - 1'b1) begin
                    acc_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = ovf_next;
                    capc_d  = capc_next;
                    state_d = ST_DONE;
                end else begin
                    run_idx_d = run_idx_q + 1'b1;
                    for (int c = 0; c < NUM_IN; c++) begin
                        acc_d[c] = acc_q[c] + stride_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            stride_q    <= '0;
            cfg_q       <= '0;
            flush_cnt_q <= '0;
            run_idx_q   <= '0;
            acc_q       <= '0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            capc_q      <= '0;
            cc_q        <= '0;
            rd_chan_q   <= '0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            stride_q    <= stride_d;
            cfg_q       <= cfg_d;
            flush_cnt_q <= flush_cnt_d;
            run_idx_q   <= run_idx_d;
            acc_q       <= acc_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            capc_q      <= capc_d;
            cc_q        <= cc_q + 64'd1;
            rd_chan_q   <= rd_chan;
            rd_ok_q     <= ({1'b0, rd_chan} < NUM_OUT_C);
        end
    end

    // Capture slot i is written at the end of run cycle i while it fits.
    logic                                cap_we;
    logic [CAP_AW-1:0]                   cap_addr;
    logic [NUM_OUT-1:0][DATA_WIDTH-1:0]  ram_rdata;

    assign cap_we   = (state_q == ST_RUN) && (run_idx_q < DEPTH_C);
    assign cap_addr = run_idx_q[CAP_AW-1:0];

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_cap
        lake_harness_capture_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (CAP_DEPTH),
            .AW         (CAP_AW)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (cap_we),
            .waddr (cap_addr),
            .wdata (dut_port_out[o*DATA_WIDTH +: DATA_WIDTH]),
            .raddr (rd_addr),
            .rdata (ram_rdata[o])
        );
    end

    // Channel select is registered alongside the RAM read so both line up.
    assign rd_data           = rd_ok_q ? ram_rdata[rd_chan_q] : '0;
    assign dut_config_memory = cfg_q;
    assign dut_flush         = flush_q;
    assign dut_port_in       = acc_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign overflow          = ovf_q;
    assign cap_count         = capc_q;
    assign cycle_count       = cc_q;

endmodule

// File: tb/tb_lake_stream_harness.sv
module tb_lake_stream_harness;

    localparam int DW    = 8;
    localparam int NI    = 3;
    localparam int NO    = 3;
    localparam int CFG   = 32;
    localparam int FC    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int AW    = 4;
    localparam int CHW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CW-1:0]     num_cycles = '0;
    logic [DW-1:0]     stride = '0;
    logic [CFG-1:0]    config_in = '0;
    logic [CFG-1:0]    dut_config_memory;
    logic              dut_flush;
    logic [NI*DW-1:0]  dut_port_in;
    logic [NO*DW-1:0]  dut_port_out;
    logic [CHW-1:0]    rd_chan = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DW-1:0]     rd_data;
    logic              busy, done, overflow;
    logic [CW-1:0]     cap_count;
    logic [63:0]       cycle_count;

    // Loopback DUT.
    assign dut_port_out = dut_port_in;

    lake_stream_harness #(
        .DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .CONFIG_MEMORY_SIZE(CFG),
        .FLUSH_CYCLES(FC), .CAP_DEPTH(DEPTH), .CYC_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
        .stride(stride), .config_in(config_in),
        .dut_config_memory(dut_config_memory), .dut_flush(dut_flush),
        .dut_port_in(dut_port_in), .dut_port_out(dut_port_out),
        .rd_chan(rd_chan), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .overflow(overflow),
        .cap_count(cap_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             due;
        logic           busy;
        logic           done;
        logic           flush;
        logic           ovf;
        logic [CW-1:0]  capc;
        logic [NI*DW-1:0] port;
        logic [CFG-1:0] cfg;
    } trace_t;

    typedef struct {
        int          due;
        int          chan;
        int          addr;
        logic [DW-1:0] data;
    } rd_t;

    trace_t trace_q[$];
    rd_t    rd_q[$];
    int     tcyc = 0;
    int     rst_rel = 0;
    int     errors = 0;
    int     checks = 0;
    trace_t te;
    rd_t    re;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // Reference ramp: value driven on channel c at run index i.
    function automatic logic [DW-1:0] ramp(input int i, input int str, input int c);
        longint v;
        v = (longint'(i) * longint'(str) + longint'(c)) % (longint'(1) << DW);
        return DW'(v);
    endfunction

    function automatic logic [NI*DW-1:0] ramp_vec(input int i, input int str);
        logic [NI*DW-1:0] v;
        for (int c = 0; c < NI; c++) v[c*DW +: DW] = ramp(i, str, c);
        return v;
    endfunction

    // Monitor: compare DUT outputs against queued expectations as they fall due.
    always @(negedge clk) begin
        while (trace_q.size() > 0 && trace_q[0].due <= tcyc) begin
            te = trace_q.pop_front();
            if (te.due < tcyc) chk("trace_missed", 64'(te.due), 64'(tcyc));
            else begin
                chk("busy", 64'(busy), 64'(te.busy));
                chk("done", 64'(done), 64'(te.done));
                chk("dut_flush", 64'(dut_flush), 64'(te.flush));
                chk("dut_port_in", 64'(dut_port_in), 64'(te.port));
                chk("overflow", 64'(overflow), 64'(te.ovf));
                chk("cap_count", 64'(cap_count), 64'(te.capc));
                chk("dut_config_memory", 64'(dut_config_memory), 64'(te.cfg));
            end
        end
        while (rd_q.size() > 0 && rd_q[0].due <= tcyc) begin
            re = rd_q.pop_front();
            if (re.due < tcyc) chk("read_missed", 64'(re.due), 64'(tcyc));
            else chk($sformatf("rd_data[%0d][%0d]", re.chan, re.addr), 64'(rd_data), 64'(re.data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic trace_t mk(input int due, input logic b, input logic d, input logic f,
                                  input logic o, input logic [CW-1:0] cc,
                                  input logic [NI*DW-1:0] p, input logic [CFG-1:0] cf);
        trace_t t;
        t.due = due; t.busy = b; t.done = d; t.flush = f; t.ovf = o;
        t.capc = cc; t.port = p; t.cfg = cf;
        return t;
    endfunction

    // One sequence. reset_at >= 0 asserts rst during that run index;
    // inj >= 0 pulses a conflicting start during that run index.
    task automatic run(input int n, input int str, input logic [CFG-1:0] cfg,
                       input int reset_at, input int inj);
        int s;
        int i;
        int last_t;
        int nv;
        s = tcyc;
        start = 1'b1; num_cycles = CW'(n); stride = DW'(str); config_in = cfg;
        last_t = (reset_at >= 0) ? FC + 1 + reset_at : FC + n + 1;
        for (int t = 0; t <= last_t; t++) begin
            if (t == 0)
                trace_q.push_back(mk(s + 1, 1, 0, 0, 0, '0, '0, cfg));
            else if (t <= FC)
                trace_q.push_back(mk(s + 1 + t, 1, 0, 1, 0, '0, '0, cfg));
            else if (t <= FC + n)
                trace_q.push_back(mk(s + 1 + t, 1, 0, 0, 0, '0, ramp_vec(t - FC - 1, str), cfg));
            else
                trace_q.push_back(mk(s + 1 + t, 0, 1, 0, n > DEPTH,
                                     CW'((n > DEPTH) ? DEPTH : n), '0, cfg));
        end
        tick();
        start = 1'b0;
        // Inputs other than start must not matter after sampling.
        num_cycles = CW'($urandom); stride = DW'($urandom); config_in = CFG'($urandom);
        while (tcyc < s + 2 + FC + n) begin
            i = tcyc - (s + 2 + FC);
            start = (i == inj);
            if (i >= 0 && i == reset_at) begin
                rst = 1'b1;
                trace_q.push_back(mk(tcyc + 1, 0, 0, 0, 0, '0, '0, '0));
                tick();
                chk("cycle_count_after_rst", cycle_count, 64'd0);
                rst = 1'b0;
                rst_rel = tcyc;
                return;
            end
            tick();
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
        chk("cycle_count", cycle_count, 64'(tcyc - rst_rel));
        nv = (n > DEPTH) ? DEPTH : n;
        for (int c = 0; c <= NO; c++) begin
            for (int a = 0; a < ((c == NO) ? 2 : nv); a++) begin
                rd_t r;
                rd_chan = CHW'(c); rd_addr = AW'(a);
                r.due = tcyc + 1; r.chan = c; r.addr = a;
                r.data = (c == NO) ? '0 : ramp(a, str, c);
                rd_q.push_back(r);
                tick();
            end
        end
        tick();
        chk("done_hold", 64'(done), 64'd1);
        chk("cfg_hold", 64'(dut_config_memory), 64'(cfg));
        tick();
    endtask

    initial begin
        repeat (3) tick();
        // Reset state
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_flush", 64'(dut_flush), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_cap_count", 64'(cap_count), 0);
        chk("rst_port_in", 64'(dut_port_in), 0);
        chk("rst_cfg", 64'(dut_config_memory), 0);
        chk("rst_rd_data", 64'(rd_data), 0);
        chk("rst_cycle_count", cycle_count, 0);
        rst = 1'b0;
        rst_rel = tcyc;
        tick();
        chk("cycle_count_idle", cycle_count, 64'(tcyc - rst_rel));

        run(10, 2, 32'hA5A5_0001, -1, -1);     // basic ramp
        run(4, 100, 32'h1234_5678, -1, -1);    // wrap: ch1 = 1,101,201,45
        run(20, 1, 32'hCAFE_0020, -1, -1);     // overflow
        run(0, 7, 32'h0000_0BAD, -1, -1);      // zero length
        run(12, 3, 32'h5555_AAAA, -1, 3);      // start during RUN ignored
        run(100, 5, 32'hDEAD_BEEF, 5, -1);     // reset at run index 5
        run(18, int'($urandom_range(1, 255)), CFG'($urandom), -1, -1);
        for (int k = 0; k < 3; k++)
            run(int'($urandom_range(0, 24)), int'($urandom_range(0, 255)), CFG'($urandom), -1, -1);

        repeat (3) tick();
        chk("queues_drained", 64'(trace_q.size() + rd_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lake_stream_harness.md
Name: lake_stream_harness

Overview:
- Synthesizable, parametrised stimulus/capture harness for a lakespec-style DUT; successor to the single-port static bench flow.
- Sequences config load, flush, and a fixed-length run in hardware.
- Drives NUM_IN input channels with per-channel ramp patterns and captures NUM_OUT output channels into on-chip buffers that can be read back after the run.
- Sits beside the DUT in emulation/FPGA builds; the host only pulses start and reads results.

Parameters:
DATA_WIDTH, 16, width of every data channel
NUM_IN, 1, number of DUT input channels driven
NUM_OUT, 1, number of DUT output channels captured
CONFIG_MEMORY_SIZE, 512, DUT config vector width in bits
FLUSH_CYCLES, 2, cycles dut_flush is held high (must be at least 1)
CAP_DEPTH, 1024, capture entries per output channel (power of 2)
CYC_W, 32, width of the run-length counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that begins a sequence; honoured in IDLE or DONE only
num_cycles  in  CYC_W  run length, sampled on start
stride  in  DATA_WIDTH  ramp increment, sampled on start
config_in  in  CONFIG_MEMORY_SIZE  DUT configuration, sampled on start
dut_config_memory  out  CONFIG_MEMORY_SIZE  registered config to DUT
dut_flush  out  1  flush to DUT
dut_port_in  out  NUM_IN*DATA_WIDTH  packed input channels; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
dut_port_out  in  NUM_OUT*DATA_WIDTH  packed DUT outputs
rd_chan  in  clog2(NUM_OUT) (min 1)  capture channel select
rd_addr  in  clog2(CAP_DEPTH)  capture entry select
rd_data  out  DATA_WIDTH  capture read data, 1-cycle latency
busy  out  1  high in LOAD, FLUSH and RUN
done  out  1  high in DONE
overflow  out  1  num_cycles exceeded CAP_DEPTH in the last run
cap_count  out  CYC_W  number of valid capture entries, equal to min(num_cycles, CAP_DEPTH)
cycle_count  out  64  free-running cycles since reset

Behaviour:
- All state is synchronous to clk. When rst is high the following values apply at the next edge:
  - state = IDLE;
  - dut_config_memory, dut_port_in, rd_data and cap_count = 0;
  - dut_flush, busy, done and overflow = 0;
  - cycle_count = 0.
- Capture RAM contents are not reset.
- rst mid-sequence aborts immediately to the reset state; no partial done is reported.
- cycle_count increments every non-reset cycle and wraps at 2^64.
- FSM states:
  - IDLE/DONE: on start, latch num_cycles, stride and config_in, clear overflow and cap_count, go to LOAD. done stays high in DONE until start or rst.
  - LOAD: 1 cycle. dut_config_memory takes the latched config at entry. Next state is FLUSH.
  - FLUSH: exactly FLUSH_CYCLES cycles with dut_flush = 1. Next state is RUN, or DONE directly if num_cycles == 0.
  - RUN: run index i goes from 0 to num_cycles-1, one value per cycle. After the last index, go to DONE.
- start in LOAD, FLUSH or RUN is ignored.
- dut_config_memory holds its value until the next LOAD, including across DONE and IDLE.
- Input stimulus:
  - During RUN cycle i, channel c = (i*stride + c) mod 2^DATA_WIDTH.
  - Implemented as a per-channel accumulator (no multiplier), registered so the value is stable for the whole cycle.
  - Outside RUN, dut_port_in = 0.
- Capture:
  - At the end of RUN cycle i, each output channel's dut_port_out slice is written to entry i of that channel, only if i < CAP_DEPTH.
  - Capture index equals run index; there is no +1 offset.
- overflow is set on entry to DONE if num_cycles > CAP_DEPTH.
- cap_count is updated on entry to DONE.
- Readback:
  - rd_data = buffer[rd_chan][rd_addr] one cycle after the address is presented.
  - Reads are legal in any state but valid only in DONE.
  - An out-of-range rd_chan returns 0.
- Arithmetic:
  - Accumulators wrap modulo 2^DATA_WIDTH.
  - The run counter is CYC_W wide; num_cycles = 2^CYC_W - 1 is legal.

Decomposition:
- lake_harness_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, RUN, DONE);
  - the localparams CAP_AW = clog2(CAP_DEPTH) and CHAN_W.
- One sub-module, lake_harness_capture_ram:
  - single write port, single registered read port, DATA_WIDTH x CAP_DEPTH;
  - instantiated NUM_OUT times.
- FSM, accumulators and read mux live in the top module.

Test Plan:
1. Loopback, single channel:
   - Stimulus: NUM_IN = NUM_OUT = 1, dut_port_out tied to dut_port_in, num_cycles = 1000, stride = 2.
   - Required: entry k reads 2k for k = 0..999; cap_count = 1000; overflow = 0; done high.
2. Flush timing:
   - Stimulus: FLUSH_CYCLES = 4, then start.
   - Required: LOAD for 1 cycle; dut_flush high for exactly 4 cycles; first RUN cycle drives 0 on channel 0; busy is high for 1 + 4 + num_cycles cycles.
3. Multi-channel with wrap:
   - Stimulus: NUM_IN = NUM_OUT = 3, loopback, DATA_WIDTH = 8, stride = 100, num_cycles = 4.
   - Required: channel 1 captures 1, 101, 201, 45 (the last value wraps: 301 mod 256).
4. Overflow:
   - Stimulus: CAP_DEPTH = 16, num_cycles = 20, stride = 1.
   - Required: overflow = 1; cap_count = 16; entries 0..15 hold 0..15.
5. Zero length and ignored start:
   - Stimulus A: num_cycles = 0.
   - Required A: FLUSH then DONE with no RUN cycles; cap_count = 0.
   - Stimulus B: a start pulse during RUN with a different stride.
   - Required B: the sequence continues unchanged.
6. Reset mid-RUN:
   - Stimulus: assert rst at run index 5 of 100.
   - Required: next cycle has state IDLE, busy = done = 0, dut_flush = 0, dut_port_in = 0, cycle_count = 0.
   - Stimulus: a fresh start afterwards.
   - Required: a full, correct run.
